fetch_unit: RTL and testbench

Parametrised instruction-fetch front end: PC register, next-PC adder and a DEPTH-entry fetch queue. The queue replaces the single IF/ID register, decoupling instruction memory from decode with a valid/ready handshake. Sits between the combinational instruction memory and the decode/parser stage of the pipelined core. Branch/jump redirects from EX/MEM flush the queue and reload the PC.

---
 rtl/riscvy_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscvy_fetch_pkg.sv
// riscvy_fetch_pkg: fetch-queue entry type, RISC-V opcodes and J/B immediate decoders.
package riscvy_fetch_pkg;
    localparam int PC_W = 64;
    localparam int INST_W = 32;
    localparam int INST_BYTES = 4;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic pred_taken;
    } fetch_entry_t;
    function automatic logic [20:0] imm_j(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction
    function automatic logic [12:0] imm_b(input logic [31:0] inst);
        return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch queue with push/pop/clear, occupancy count and zeroed head when empty.
module fetch_fifo
    import riscvy_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  T                             wdata,
    output T                             head,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    T mem [DEPTH];
    logic [AW-1:0] wr, rd;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr <= '0;
            rd <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr <= '0;
            rd <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push && !clear) mem[wr] <= wdata;
    assign valid = occupancy != '0;
    assign head = valid ? mem[rd] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC logic and fetch queue feeding decode.
// FETCH_BTFN_EN enables static backward-taken/JAL-taken prediction and the dec_pred_taken output.
module fetch_unit
    import riscvy_fetch_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [ILEN-1:0]              imem_inst,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [ILEN-1:0]              dec_inst,
    output logic [XLEN-1:0]              dec_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef FETCH_BTFN_EN
    ,
    output logic                         dec_pred_taken
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic pred_taken;
    } entry_t;
    logic [XLEN-1:0] pc, next_pc;
    logic push, pop, pred;
    logic [1:0] unused_lsb;
    entry_t wdata, head;
    assign pop = dec_valid && dec_ready && !redirect_valid;
    assign push = !redirect_valid && (occupancy != CW'(DEPTH) || pop);
    assign imem_addr = pc;
    assign unused_lsb = redirect_pc[1:0];
`ifdef FETCH_BTFN_EN
    logic is_jal, is_br;
    logic [20:0] j_imm;
    logic [12:0] b_imm;
    assign j_imm = imm_j(imem_inst[31:0]);
    assign b_imm = imm_b(imem_inst[31:0]);
    assign is_jal = imem_inst[6:0] == OPC_JAL;
    assign is_br = imem_inst[6:0] == OPC_BRANCH && imem_inst[31];
    assign pred = is_jal || is_br;
    assign next_pc = is_jal ? pc + {{(XLEN-21){j_imm[20]}}, j_imm} :
                     is_br  ? pc + {{(XLEN-13){b_imm[12]}}, b_imm} :
                              pc + XLEN'(INST_BYTES);
    assign dec_pred_taken = head.pred_taken;
`else
    logic unused_pred;
    assign pred = 1'b0;
    assign next_pc = pc + XLEN'(INST_BYTES);
    assign unused_pred = head.pred_taken;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (push) pc <= next_pc;
    end
    assign wdata = {pc, imem_inst, pred};
    fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .wdata     (wdata),
        .head      (head),
        .valid     (dec_valid),
        .occupancy (occupancy)
    );
    assign dec_inst = head.inst;
    assign dec_pc = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] imem_addr, redirect_pc, dec_pc, w_addr, w_dec_pc;
    logic [31:0] imem_inst, dec_inst, w_dec_inst;
    logic redirect_valid = 1'b0, dec_ready = 1'b1, dec_valid, w_dec_valid;
    logic [2:0] occupancy, w_occ;
`ifdef FETCH_BTFN_EN
    logic dec_pred_taken, w_pred;
`endif
    int mem_mode = 0;
    int n_checks = 0;
    int n_fail = 0;

    fetch_unit #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
        .dec_pc(dec_pc), .occupancy(occupancy)
`ifdef FETCH_BTFN_EN
        , .dec_pred_taken(dec_pred_taken)
`endif
    );

    fetch_unit #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_inst(32'h00000013),
        .redirect_valid(1'b0), .redirect_pc(64'h0),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready), .dec_inst(w_dec_inst),
        .dec_pc(w_dec_pc), .occupancy(w_occ)
`ifdef FETCH_BTFN_EN
        , .dec_pred_taken(w_pred)
`endif
    );

    function automatic logic [31:0] mem_fn(input logic [63:0] a, input int mode);
        logic [31:0] h;
        h = (a[31:0] * 32'h9E3779B1) ^ a[63:32];
        if (mode == 1) return {h[31:7], 7'h13};
        if (mode == 2) begin
            if (a == 64'h40) return 32'hFE000CE3;
            if (a == 64'h38) return 32'h00000463;
            if (a == 64'h50) return 32'h0100006F;
        end
        return 32'h00000013;
    endfunction
    assign imem_inst = mem_fn(imem_addr, mem_mode);

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic pred;
    } ent_t;
    ent_t mq[$];
    logic [63:0] mpc;

    function automatic logic m_pred(input logic [31:0] i);
`ifdef FETCH_BTFN_EN
        return i[6:0] == 7'b1101111 || (i[6:0] == 7'b1100011 && i[31]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] m_next(input logic [63:0] p, input logic [31:0] i);
        longint off;
        off = 4;
`ifdef FETCH_BTFN_EN
        if (i[6:0] == 7'b1101111) off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
        else if (i[6:0] == 7'b1100011 && i[31]) off = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
`endif
        return p + off;
    endfunction

    task automatic tick(input logic rv, input logic [63:0] rpc, input logic rdy);
        logic do_pop, do_push;
        ent_t e;
        redirect_valid = rv;
        redirect_pc = rpc;
        dec_ready = rdy;
        if (rv) begin
            mq.delete();
            mpc = {rpc[63:2], 2'b00};
        end else begin
            do_pop = mq.size() != 0 && rdy;
            do_push = mq.size() < DEPTH || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc = mpc;
                e.inst = mem_fn(mpc, mem_mode);
                e.pred = m_pred(e.inst);
                mq.push_back(e);
                mpc = m_next(mpc, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        mq.delete();
        mpc = 64'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        mem_mode = 0;
        for (int k = 0; k < 3; k++) tick(1'b0, 64'h0, 1'b0);
        reset = 1'b0;
        mq.delete();
        mpc = 64'h0;
        #2;
        n_checks++;
        if ({dec_valid, occupancy, dec_pc, dec_inst, imem_addr} !== {1'b0, 3'd0, 64'h0, 32'h0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_async: valid=%0b occ=%0d pc=%h inst=%h addr=%h, want all zero", dec_valid, occupancy, dec_pc, dec_inst, imem_addr);
        end
        n_checks++;
        if ({w_addr, w_dec_valid} !== {WRAP_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_pc: addr=%h valid=%0b, want %h 0", w_addr, w_dec_valid, WRAP_PC);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1'b0, 64'h0, 1'b1);
        n_checks++;
        if ({dec_valid, dec_pc, imem_addr} !== {1'b1, 64'h0, 64'h4}) begin
            n_fail++;
            $display("FAIL reset_release: valid=%0b pc=%h addr=%h, want 1 0 4", dec_valid, dec_pc, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        mem_mode = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 64'h0, 1'b1);
            n_checks++;
            if ({dec_valid, dec_pc, dec_inst, imem_addr, occupancy} !== {1'b1, 64'(4 * (k - 1)), 32'h13, 64'(4 * k), 3'd1}) begin
                n_fail++;
                $display("FAIL stream k=%0d: valid=%0b pc=%h inst=%h addr=%h occ=%0d, want 1 %h 13 %h 1",
                         k, dec_valid, dec_pc, dec_inst, imem_addr, occupancy, 4 * (k - 1), 4 * k);
            end
        end
    endtask

    task automatic test_stall();
        int occ;
        do_reset();
        mem_mode = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 64'h0, 1'b0);
            occ = k < DEPTH ? k : DEPTH;
            n_checks++;
            if ({occupancy, imem_addr, dec_pc, dec_valid} !== {3'(occ), 64'(4 * occ), 64'h0, 1'b1}) begin
                n_fail++;
                $display("FAIL stall k=%0d: occ=%0d addr=%h pc=%h valid=%0b, want %0d %h 0 1",
                         k, occupancy, imem_addr, dec_pc, dec_valid, occ, 4 * occ);
            end
        end
        for (int j = 1; j <= 6; j++) begin
            tick(1'b0, 64'h0, 1'b1);
            n_checks++;
            if ({occupancy, dec_pc, imem_addr} !== {3'd4, 64'(4 * j), 64'(16 + 4 * j)}) begin
                n_fail++;
                $display("FAIL full_overlap j=%0d: occ=%0d pc=%h addr=%h, want 4 %h %h",
                         j, occupancy, dec_pc, imem_addr, 4 * j, 16 + 4 * j);
            end
        end
    endtask

    task automatic test_redirect();
        logic [63:0] want_pc [5];
        logic [63:0] want_addr [5];
        logic [63:0] rpc [5];
        logic rv [5];
        logic want_valid [5];
        do_reset();
        mem_mode = 0;
        for (int k = 0; k < 3; k++) tick(1'b0, 64'h0, 1'b0);
        n_checks++;
        if (occupancy !== 3'd3) begin
            n_fail++;
            $display("FAIL redirect_pre: occ=%0d, want 3", occupancy);
        end
        tick(1'b1, 64'h100, 1'b1);
        n_checks++;
        if ({occupancy, dec_valid, dec_pc, imem_addr} !== {3'd0, 1'b0, 64'h0, 64'h100}) begin
            n_fail++;
            $display("FAIL redirect_flush: occ=%0d valid=%0b pc=%h addr=%h, want 0 0 0 100", occupancy, dec_valid, dec_pc, imem_addr);
        end
        rv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rpc = '{64'h0, 64'h103, 64'h200, 64'h300, 64'h0};
        want_valid = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        want_pc = '{64'h100, 64'h0, 64'h0, 64'h0, 64'h300};
        want_addr = '{64'h104, 64'h100, 64'h200, 64'h300, 64'h304};
        for (int k = 0; k < 5; k++) begin
            tick(rv[k], rpc[k], 1'b1);
            n_checks++;
            if ({dec_valid, dec_pc, imem_addr} !== {want_valid[k], want_pc[k], want_addr[k]}) begin
                n_fail++;
                $display("FAIL redirect_seq k=%0d: valid=%0b pc=%h addr=%h, want %0b %h %h",
                         k, dec_valid, dec_pc, imem_addr, want_valid[k], want_pc[k], want_addr[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] want_pc [3];
        logic [63:0] want_addr [3];
        want_pc = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        want_addr = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
        do_reset();
        mem_mode = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 64'h0, 1'b1);
            n_checks++;
            if ({w_dec_valid, w_dec_pc, w_addr} !== {1'b1, want_pc[k], want_addr[k]}) begin
                n_fail++;
                $display("FAIL wrap k=%0d: valid=%0b pc=%h addr=%h, want 1 %h %h",
                         k, w_dec_valid, w_dec_pc, w_addr, want_pc[k], want_addr[k]);
            end
        end
    endtask

    task automatic test_random();
        logic ev;
        logic [63:0] epc;
        logic [31:0] einst;
        do_reset();
        mem_mode = 1;
        for (int k = 0; k < 400; k++) begin
            tick($urandom_range(0, 9) == 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0);
            ev = mq.size() != 0;
            epc = ev ? mq[0].pc : 64'h0;
            einst = ev ? mq[0].inst : 32'h0;
            n_checks++;
            if ({dec_valid, dec_pc, dec_inst, occupancy, imem_addr} !== {ev, epc, einst, 3'(mq.size()), mpc}) begin
                n_fail++;
                $display("FAIL random k=%0d: valid=%0b pc=%h inst=%h occ=%0d addr=%h, want %0b %h %h %0d %h",
                         k, dec_valid, dec_pc, dec_inst, occupancy, imem_addr, ev, epc, einst, mq.size(), mpc);
            end
        end
    endtask

`ifdef FETCH_BTFN_EN
    task automatic test_btfn();
        do_reset();
        mem_mode = 2;
        tick(1'b1, 64'h40, 1'b1);
        tick(1'b0, 64'h0, 1'b1);
        n_checks++;
        if ({imem_addr, dec_pc, dec_pred_taken} !== {64'h38, 64'h40, 1'b1}) begin
            n_fail++;
            $display("FAIL btfn_back: addr=%h pc=%h pred=%0b, want 38 40 1", imem_addr, dec_pc, dec_pred_taken);
        end
        tick(1'b0, 64'h0, 1'b1);
        n_checks++;
        if ({imem_addr, dec_pc, dec_pred_taken} !== {64'h3C, 64'h38, 1'b0}) begin
            n_fail++;
            $display("FAIL btfn_fwd: addr=%h pc=%h pred=%0b, want 3c 38 0", imem_addr, dec_pc, dec_pred_taken);
        end
        tick(1'b1, 64'h50, 1'b1);
        tick(1'b0, 64'h0, 1'b1);
        n_checks++;
        if ({imem_addr, dec_pc, dec_pred_taken} !== {64'h60, 64'h50, 1'b1}) begin
            n_fail++;
            $display("FAIL btfn_jal: addr=%h pc=%h pred=%0b, want 60 50 1", imem_addr, dec_pc, dec_pred_taken);
        end
        n_checks++;
        if (mpc !== imem_addr) begin
            n_fail++;
            $display("FAIL btfn_model: addr=%h, want %h", imem_addr, mpc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_random();
`ifdef FETCH_BTFN_EN
        test_btfn();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
